// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IDLE/RUN/HALT control, IF/ID register and branch-target LUT.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int IW   = 9,
  parameter int PCW  = 10,
  parameter int LUTD = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [PCW-1:0]           start_pc,
  input  logic                     stall,
  output logic [PCW-1:0]           imem_addr,
  input  logic [IW-1:0]            imem_data,
  input  logic                     branch,
  input  logic                     branch_taken,
  input  logic                     lut_we,
  input  logic [$clog2(LUTD)-1:0]  lut_addr,
  input  logic [PCW-1:0]           lut_data,
  output logic [IW-1:0]            ir,
  output logic [PCW-1:0]           ir_pc,
  output logic                     ir_valid,
  output logic [2:0]               op_code,
  output logic [1:0]               func,
  output logic                     mov_func,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]              cycle_cnt,
  output logic [15:0]              instr_cnt,
`endif
  output logic                     done
);

  localparam int LAW = $clog2(LUTD);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t         state, state_nxt;
  logic [PCW-1:0] pc, pc_nxt;
  logic [IW-1:0]  ir_nxt;
  logic [PCW-1:0] ir_pc_nxt;
  logic           ir_valid_nxt;
  logic           load;
  logic           start_go;
  logic [PCW-1:0] lut [LUTD];

  assign imem_addr = pc;
  assign op_code   = ir[IW-1:IW-3];
  assign func      = ir[IW-4:IW-5];
  assign mov_func  = ir[IW-4];
  assign done      = (state == HALT);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = ir_valid;
    load         = 1'b0;
    start_go     = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nxt       = start_pc;
          ir_valid_nxt = 1'b0;
          state_nxt    = RUN;
          start_go     = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          // HALT beats branch beats sequential fetch; the first two discard the word on imem_data.
          if (ir_valid && op_code == 3'b111) begin
            state_nxt    = HALT;
            ir_valid_nxt = 1'b0;
          end else if (ir_valid && branch && branch_taken) begin
            pc_nxt       = lut[ir[LAW-1:0]];
            ir_valid_nxt = 1'b0;
          end else begin
            ir_nxt       = imem_data;
            ir_pc_nxt    = pc;
            ir_valid_nxt = 1'b1;
            pc_nxt       = pc + PCW'(1);
            load         = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_valid <= ir_valid_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < LUTD; i++) lut[i] <= '0;
    end else if (lut_we && state != RUN) begin
      lut[lut_addr] <= lut_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (start_go) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state == RUN) begin
      if (cycle_cnt != '1)         cycle_cnt <= cycle_cnt + 16'd1;
      if (load && instr_cnt != '1) instr_cnt <= instr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control decoder.
- Owns the program counter, the start/halt state machine, the IF/ID instruction register and a 16-entry branch-target LUT.
- Slices the registered 9-bit instruction into op_code/func/mov_func for the decoder.
- Redirects the PC when the decoder's Branch and the ALU's branch_taken both assert.

Parameters:
- IW, 9, instruction width; op=[8:6], func=[5:4], mov_func=[5], LUT index=[3:0]
- PCW, 10, program counter / instruction-memory address width
- LUTD, 16, branch-target LUT depth (index width 4)

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- start  input  1  pulse; begins execution at start_pc (honoured in IDLE or HALT only)
- start_pc  input  PCW  first PC loaded on start
- stall  input  1  freezes PC, IR and FSM for the cycle
- imem_addr  output  PCW  instruction memory address (= pc, combinational)
- imem_data  input  IW  instruction word at imem_addr (combinational-read ROM)
- branch  input  1  Branch from control decoder for the instruction in IR
- branch_taken  input  1  ALU compare result for the instruction in IR
- lut_we  input  1  LUT write enable
- lut_addr  input  4  LUT write index
- lut_data  input  PCW  LUT write data (absolute target PC)
- ir  output  IW  registered instruction
- ir_pc  output  PCW  PC of the instruction in ir
- ir_valid  output  1  ir holds a live instruction
- op_code  output  3  ir[8:6]
- func  output  2  ir[5:4]
- mov_func  output  1  ir[5]
- done  output  1  high while in HALT

Behaviour:
- FSM states are IDLE, RUN and HALT.
- Reset, asynchronous, active-high:
  - state=IDLE; pc, ir and ir_pc all 0.
  - ir_valid=0, done=0.
  - All LUT entries 0.
  - Reset mid-run takes effect immediately, with no completion of the in-flight instruction.
- LUT writes:
  - Accepted on a clock edge with lut_we=1 only in IDLE or HALT; ignored in RUN.
  - A write and a start in the same cycle: the write lands; start proceeds.
- IDLE or HALT with start=1 (stall ignored):
  - pc<=start_pc, ir_valid<=0, done<=0, state<=RUN.
- RUN, stall=1: every register holds; decoder outputs stay stable.
- RUN, stall=0, priority highest first:
  1. ir_valid && op_code==3'b111 (HALT): state<=HALT, ir_valid<=0, pc holds (the fetched word is discarded).
  2. ir_valid && branch && branch_taken: pc<=lut[ir[3:0]], ir_valid<=0. This squashes the sequential word fetched this cycle, giving exactly one bubble.
  3. Otherwise: ir<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
- Branch and HALT cannot coincide, since they are distinct opcodes.
- branch or branch_taken alone, or either with ir_valid=0, has no effect.
- PC increment wraps modulo 2^PCW (2^PCW-1 -> 0), with no flag.
- start in RUN is ignored.
- ir, ir_pc and decoder fields retain their last value when ir_valid=0; downstream must qualify them with ir_valid.
- done=1 exactly while state==HALT.
- Taken-branch latency: the target instruction appears in ir 2 edges after the branch instruction is first valid in ir.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[15:0] and instr_cnt[15:0].
  - cycle_cnt increments every RUN cycle, stalls included.
  - instr_cnt increments on each rule-3 load.
  - Both saturate at 16'hFFFF.
  - Both clear on start and on Reset; both hold in IDLE and HALT.
- Undefined: the ports and logic do not exist; all other behaviour is identical.

Test Plan:
- Reset during RUN -> within the same cycle: state IDLE, pc=0, ir_valid=0, done=0; a subsequent start at 0 fetches from address 0.
- LUT load lut[3]=0x040 in IDLE, start with start_pc=0x010 -> imem_addr sequence 0x010, 0x011, 0x012; ir_pc lags imem_addr by 1; ir_valid rises 1 cycle after start.
- Branch at 0x012 with ir[3:0]=3, branch=1, branch_taken=1 -> next cycle ir_valid=0 and pc=0x040; the following cycle ir_pc=0x040; with branch_taken=0, pc continues to 0x013 and there is no bubble.
- stall held for 3 cycles mid-run -> pc, ir and ir_valid unchanged for those 3 cycles; resumes at the same pc; under FETCH_PERF_CNT_EN, cycle_cnt +3 and instr_cnt +0.
- ir=9'b111_000000 valid -> next cycle done=1, ir_valid=0, pc frozen; a lut write then succeeds; start with start_pc=0x000 -> done=0, RUN.
- start_pc=0x3FF (PCW=10) -> imem_addr 0x3FF then 0x000.
